// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 instruction/data memory model.
package lc3_mem_pkg;

  // Per-port access sequencing: accept, optional wait states, respond.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h3000;
  localparam logic [15:0] DEF_FILL      = 16'h0000;
  localparam int          LAT_W         = 4;

endpackage

// File: rtl/lc3_mem_port.sv
// One memory access port: request capture, wait-state counter, address
// decode and registered response. The array itself lives in the parent,
// which feeds back the word at the captured index through rdata.
module lc3_mem_port
  import lc3_mem_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int                LAT        = 0,
  parameter logic [DATA_W-1:0] FILL       = DEF_FILL,
  parameter bit                WR_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  hold,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W-1:0]     rdata,
  output logic [DEPTH_LOG2-1:0] idx,
  output logic                  wr,
  output logic [DATA_W-1:0]     wdata,
  output logic                  resp,
  output logic                  mapped,
  output logic [DATA_W-1:0]     dout,
  output logic                  complete
);

  localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT);

  mem_state_e            state;
  logic [LAT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     off;
  logic                  in_win;
  logic                  take;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic                  cap_map;
  logic                  cap_rd;
  logic [DATA_W-1:0]     cap_din;

  // Offset wraps at ADDR_W bits, so addresses below the base land far out
  // of the window rather than going negative.
  assign off    = addr - BASE_ADDR;
  assign in_win = (off >> DEPTH_LOG2) == '0;
  assign take   = (state == IDLE) && req && !hold;

  // Latch the request fields on acceptance; they stay frozen until RESP.
  always_ff @(posedge clk) begin
    if (take) begin
      cap_idx <= off[DEPTH_LOG2-1:0];
      cap_map <= in_win;
      cap_rd  <= rd || !WR_EN;
      cap_din <= din;
    end
  end

  // Port sequencer with registered completion pulse and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      complete <= 1'b0;
      dout     <= '0;
    end else begin
      complete <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            cnt   <= LAT_V;
            state <= (LAT_V == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt <= LAT_W'(1)) state <= RESP;
          else                  cnt   <= cnt - LAT_W'(1);
        end
        RESP: begin
          complete <= 1'b1;
          if (cap_rd) dout <= cap_map ? rdata : FILL;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign idx    = cap_idx;
  assign wdata  = cap_din;
  assign resp   = (state == RESP);
  assign mapped = cap_map;
  assign wr     = WR_EN && (state == RESP) && !cap_rd && cap_map;

endmodule

// File: rtl/lc3_mem_model.sv
// LC3 bench memory: separate instruction and data arrays behind two
// independent wait-state ports, a backdoor preload path, a fetch counter
// with end-of-test flag and a sticky unmapped-access flag.
module lc3_mem_model
  import lc3_mem_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int                I_LAT      = 0,
  parameter int                D_LAT      = 0,
  parameter logic [DATA_W-1:0] FILL       = DEF_FILL,
  parameter int                DYN_LIMIT  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              Data_en,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [31:0]       fetch_cnt,
  output logic              done,
  output logic              addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     imem [DEPTH];
  logic [DATA_W-1:0]     dmem [DEPTH];

  logic [DEPTH_LOG2-1:0] i_idx, d_idx, load_idx;
  logic                  i_wr, d_wr, i_resp, d_resp, i_map, d_map, load_map;
  logic [DATA_W-1:0]     i_wdata, d_wdata, i_rdata, d_rdata;
  logic [ADDR_W-1:0]     load_off;

  assign load_off = load_addr - BASE_ADDR;
  assign load_map = (load_off >> DEPTH_LOG2) == '0;
  assign load_idx = load_off[DEPTH_LOG2-1:0];

  assign i_rdata = imem[i_idx];
  assign d_rdata = dmem[d_idx];

  lc3_mem_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
    .BASE_ADDR(BASE_ADDR), .LAT(I_LAT), .FILL(FILL), .WR_EN(1'b0)
  ) u_iport (
    .clk(clk), .reset(reset), .req(instrmem_rd), .hold(load_en),
    .rd(1'b1), .addr(pc), .din('0), .rdata(i_rdata),
    .idx(i_idx), .wr(i_wr), .wdata(i_wdata), .resp(i_resp), .mapped(i_map),
    .dout(Instr_dout), .complete(complete_instr)
  );

  lc3_mem_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
    .BASE_ADDR(BASE_ADDR), .LAT(D_LAT), .FILL(FILL), .WR_EN(1'b1)
  ) u_dport (
    .clk(clk), .reset(reset), .req(Data_en), .hold(load_en),
    .rd(Data_rd), .addr(Data_addr), .din(Data_din), .rdata(d_rdata),
    .idx(d_idx), .wr(d_wr), .wdata(d_wdata), .resp(d_resp), .mapped(d_map),
    .dout(Data_dout), .complete(complete_data)
  );

  // Instruction array: port write path is tied off, only the backdoor writes.
  always_ff @(posedge clk) begin
    if (i_wr) imem[i_idx] <= i_wdata;
    if (load_en && !load_sel && load_map) imem[load_idx] <= load_data;
  end

  // Data array: the backdoor is written last so it wins a same-address clash.
  always_ff @(posedge clk) begin
    if (d_wr) dmem[d_idx] <= d_wdata;
    if (load_en && load_sel && load_map) dmem[load_idx] <= load_data;
  end

  // Saturating fetch count and sticky unmapped-access flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      addr_err  <= 1'b0;
    end else begin
      if (i_resp && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if ((i_resp && !i_map) || (d_resp && !d_map)) addr_err <= 1'b1;
    end
  end

  assign done = fetch_cnt >= 32'(DYN_LIMIT);

endmodule

// File: tb/tb_lc3_mem_model.sv
// Randomized self-checking bench for lc3_mem_model against a word-level
// reference model of both memories, the fetch counter and the error flag.
`timescale 1ns/1ps
module tb_lc3_mem_model;

  localparam int          DEPTH_LOG2 = 10;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [15:0] BASE       = 16'h3000;
  localparam logic [15:0] FILL       = 16'hDEAD;
  localparam int          I_LAT      = 3;
  localparam int          D_LAT      = 2;
  localparam int          DYN_LIMIT  = 6;
  localparam int          TMO        = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instrmem_rd = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        Data_en = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = '0;
  logic [15:0] Data_din = '0;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        load_en = 1'b0;
  logic        load_sel = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [31:0] fetch_cnt;
  logic        done;
  logic        addr_err;

  lc3_mem_model #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE),
    .I_LAT(I_LAT), .D_LAT(D_LAT), .FILL(FILL), .DYN_LIMIT(DYN_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout),
    .complete_instr(complete_instr),
    .Data_en(Data_en), .Data_rd(Data_rd), .Data_addr(Data_addr),
    .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
    .load_data(load_data),
    .fetch_cnt(fetch_cnt), .done(done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [15:0] imem_m [DEPTH];
  logic [15:0] dmem_m [DEPTH];
  int          fetch_m = 0;
  logic        err_m = 1'b0;
  logic [15:0] ddout_m = '0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int offset_of(input logic [15:0] a);
    return int'(a) - int'(BASE);
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    int o;
    o = offset_of(a);
    return (o >= 0) && (o < DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_load(input bit sel, input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    if (is_mapped(a)) begin
      if (sel) dmem_m[offset_of(a)] = d;
      else     imem_m[offset_of(a)] = d;
    end
  endtask

  // Fetch with optional backdoor activity holding off acceptance; the last
  // held cycle rewrites the fetched word itself.
  task automatic do_fetch(input logic [15:0] a, input int hold_n, output int at);
    int lat;
    logic [15:0] exp;
    instrmem_rd = 1'b1; pc = a; lat = 0;
    for (int h = 0; h < hold_n; h++) begin
      if (h == hold_n - 1) bd_load(1'b0, a, 16'($urandom));
      else bd_load(1'b1, BASE + 16'($urandom_range(0, DEPTH - 1)), 16'($urandom));
      lat++;
    end
    tick(); lat++;
    instrmem_rd = 1'b0; pc = 16'($urandom);
    while (!complete_instr && lat < TMO) begin tick(); lat++; end
    at = cyc;
    chk("fetch_lat", lat, hold_n + I_LAT + 2);
    exp = is_mapped(a) ? imem_m[offset_of(a)] : FILL;
    if (!is_mapped(a)) err_m = 1'b1;
    fetch_m++;
    chk("instr_dout", Instr_dout, exp);
    chk("fetch_cnt", fetch_cnt, fetch_m);
    chk("done", done, fetch_m >= DYN_LIMIT);
    chk("addr_err_i", addr_err, err_m);
    tick();
    chk("instr_pulse", complete_instr, 0);
  endtask

  task automatic do_data(input bit rd, input logic [15:0] a, input logic [15:0] d, output int at);
    int lat;
    Data_en = 1'b1; Data_rd = rd; Data_addr = a; Data_din = d; lat = 0;
    tick(); lat++;
    Data_en = 1'b0; Data_rd = 1'($urandom); Data_addr = 16'($urandom); Data_din = 16'($urandom);
    while (!complete_data && lat < TMO) begin tick(); lat++; end
    at = cyc;
    chk("data_lat", lat, D_LAT + 2);
    if (is_mapped(a)) begin
      if (rd) ddout_m = dmem_m[offset_of(a)];
      else    dmem_m[offset_of(a)] = d;
    end else begin
      err_m = 1'b1;
      if (rd) ddout_m = FILL;
    end
    chk("data_dout", Data_dout, ddout_m);
    chk("addr_err_d", addr_err, err_m);
    tick();
    chk("data_pulse", complete_data, 0);
  endtask

  // Request held high: completions must be LAT+2 apart, one cycle wide.
  task automatic fetch_stream(input logic [15:0] a, input int n);
    int last, w;
    instrmem_rd = 1'b1; pc = a; last = 0;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin tick(); w++; end while (!complete_instr && w < TMO);
      if (k > 0) chk("stream_gap", cyc - last, I_LAT + 2);
      last = cyc;
      fetch_m++;
      chk("stream_dout", Instr_dout, imem_m[offset_of(a)]);
      chk("stream_cnt", fetch_cnt, fetch_m);
      if (k == n - 1) instrmem_rd = 1'b0;
      tick();
      chk("stream_pulse", complete_instr, 0);
    end
  endtask

  // Backdoor load lands on the same edge as the port's write.
  task automatic collide(input logic [15:0] a);
    logic [15:0] wv, lv;
    int at;
    wv = 16'($urandom); lv = ~wv;
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = a; Data_din = wv;
    tick();
    Data_en = 1'b0;
    repeat (D_LAT) tick();
    load_en = 1'b1; load_sel = 1'b1; load_addr = a; load_data = lv;
    tick();
    load_en = 1'b0;
    chk("coll_complete", complete_data, 1);
    dmem_m[offset_of(a)] = lv;
    tick();
    do_data(1'b1, a, '0, at);
    chk("coll_load_wins", Data_dout, lv);
  endtask

  // Reset while a write waits: no completion, the word keeps its old value.
  task automatic reset_abort(input logic [15:0] a);
    logic [15:0] old;
    bit seen;
    int at;
    old = dmem_m[offset_of(a)];
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = a; Data_din = ~old;
    tick();
    Data_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_idout", Instr_dout, 0);
    chk("rst_ddout", Data_dout, 0);
    chk("rst_done", done, 0);
    tick();
    reset = 1'b0;
    fetch_m = 0; err_m = 1'b0; ddout_m = '0;
    seen = 1'b0;
    for (int i = 0; i < D_LAT + 3; i++) begin
      tick();
      if (complete_data) seen = 1'b1;
    end
    chk("rst_no_complete", seen, 0);
    do_data(1'b1, a, '0, at);
    chk("rst_kept", Data_dout, old);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int          ai, ad, at, kind;
    logic [15:0] a, last_w;
    last_w = BASE;

    tick(); tick();
    chk("reset_ci", complete_instr, 0);
    chk("reset_cd", complete_data, 0);
    chk("reset_idout", Instr_dout, 0);
    chk("reset_ddout", Data_dout, 0);
    chk("reset_cnt", fetch_cnt, 0);
    chk("reset_done", done, 0);
    chk("reset_err", addr_err, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      bd_load(1'b0, BASE + 16'(i), 16'($urandom));
      bd_load(1'b1, BASE + 16'(i), 16'($urandom));
    end

    // First fetch after a backdoor load
    bd_load(1'b0, 16'h3000, 16'h1261);
    do_fetch(16'h3000, 0, at);
    chk("first_word", Instr_dout, 16'h1261);
    chk("first_cnt", fetch_cnt, 1);

    fetch_stream(16'h3005, 4);

    // Write then read back; the write leaves Data_dout alone
    do_data(1'b0, 16'h3010, 16'hBEEF, at);
    do_data(1'b1, 16'h3010, '0, at);
    chk("beef", Data_dout, 16'hBEEF);

    // Unmapped accesses on both sides of the window
    do_fetch(16'h2FFF, 0, at);
    chk("fill_low", Instr_dout, FILL);
    do_fetch(16'h3400, 0, at);
    chk("fill_high", Instr_dout, FILL);
    do_data(1'b0, 16'h2FFF, 16'h1234, at);
    do_fetch(16'h3001, 0, at);
    chk("err_sticky", addr_err, 1);

    // Both ports finishing on the same edge
    fork
      do_fetch(16'h3100, 0, ai);
      begin tick(); do_data(1'b1, 16'h3200, '0, ad); end
    join
    chk("same_cycle", ai, ad);

    do_fetch(16'h3123, 3, at);
    collide(16'h3040);
    reset_abort(16'h3020);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = BASE + 16'($urandom_range(0, DEPTH - 1));
      if (kind < 4) do_fetch(a, (kind == 0) ? int'($urandom_range(1, 3)) : 0, at);
      else if (kind < 7) do_data(1'b1, ($urandom_range(0, 1) == 1) ? last_w : a, '0, at);
      else if (kind < 9) begin
        last_w = a;
        do_data(1'b0, a, 16'($urandom), at);
      end else bd_load(1'($urandom), a, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lc3_mem_model.md
# lc3_mem_model

Parametrised, synthesisable instruction/data memory model for the LC3 pipeline bench. It has independent instruction-fetch and data-access ports, each with a programmable wait-state latency and a one-cycle completion pulse. It also has a backdoor preload port and a dynamic fetch counter with an end-of-test flag. It sits between the LC3 DUT memory interface (`instrmem_rd`, `Data_rd`, `complete_instr`, `complete_data`) and the bench stimulus.

## Interface
- `ADDR_W`, 16: address width of both ports.
- `DATA_W`, 16: word width.
- `DEPTH_LOG2`, 10: log2 of words per memory; window is `BASE_ADDR .. BASE_ADDR + 2**DEPTH_LOG2 - 1`.
- `BASE_ADDR`, 16'h3000: first mapped address for both memories.
- `I_LAT`, 0: instruction wait states (0..15).
- `D_LAT`, 0: data wait states (0..15).
- `FILL`, 16'h0000: word returned for unmapped reads.
- `DYN_LIMIT`, 1000: fetch count at which `done` asserts.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `instrmem_rd`  in  1  instruction read request (level).
- `pc`  in  ADDR_W  fetch address.
- `Instr_dout`  out  DATA_W  fetched word.
- `complete_instr`  out  1  one-cycle fetch completion.
- `Data_en`  in  1  data access request (level).
- `Data_rd`  in  1  1 = read, 0 = write.
- `Data_addr`  in  ADDR_W  data address.
- `Data_din`  in  DATA_W  write data.
- `Data_dout`  out  DATA_W  read data.
- `complete_data`  out  1  one-cycle data completion.
- `load_en`, `load_sel`, `load_addr`, `load_data`  in  1/1/ADDR_W/DATA_W  backdoor write; `load_sel` 0 = instruction, 1 = data memory.
- `fetch_cnt`  out  32  completed fetches.
- `done`  out  1  `fetch_cnt >= DYN_LIMIT`.
- `addr_err`  out  1  sticky flag: an unmapped access occurred.

## Operation
- Each port has its own FSM: IDLE -> WAIT (counter loaded with the port's latency) -> RESP -> IDLE.
  - If the latency is 0, IDLE goes straight to RESP.
- A request is sampled in IDLE. Address, read/write and write data are captured at that edge. Inputs are ignored until the FSM returns to IDLE.
- In RESP the port registers its data output, pulses its complete output for exactly one cycle, and returns to IDLE.
  - If the request is still high in IDLE, it is sampled as a new request. No back-to-back response without an intervening IDLE cycle.
- Mapped address means `addr - BASE_ADDR < 2**DEPTH_LOG2`, computed with ADDR_W-bit unsigned wrap.
  - An unmapped read returns `FILL` and sets `addr_err`.
  - An unmapped write is dropped and sets `addr_err`.
- A data write updates the array on the RESP edge. `Data_dout` holds its previous value on writes.
- `load_en` has priority over both ports:
  - While it is high, FSMs in IDLE do not sample requests.
  - FSMs already in WAIT or RESP continue.
  - A RESP write and a load to the same data address in the same cycle: the load wins.
- `fetch_cnt` increments on each `complete_instr` and saturates at 2^32-1.
- `done` is combinational from `fetch_cnt`.
- The two ports are fully independent and may complete in the same cycle.

## Timing
- Reset (async assert, sync release), all of the following:
  - both FSMs go to IDLE
  - `complete_instr`, `complete_data` = 0
  - `Instr_dout`, `Data_dout` = 0
  - `fetch_cnt` = 0, `done` = 0, `addr_err` = 0
  - memory arrays are not cleared
- Request sampled at edge k -> complete high during cycle k+1+LAT, with data valid in that same cycle.
- Minimum request-to-request spacing is LAT+2 cycles.
- Reset mid-transaction aborts it: no completion is issued, and a pending write is not performed.
- A backdoor load is visible to a port request sampled at the next edge.

## Structure
- Package `lc3_mem_pkg` holds:
  - the `mem_state_e` enum (IDLE, WAIT, RESP)
  - the default `BASE_ADDR` and `FILL` constants
  - the `LAT_W` = 4 constant
- Sub-module `lc3_mem_port` contains one FSM, the latency counter, the capture registers and the address decode.
  - It is instantiated twice; the instruction instance has its write path tied off.
- The top level holds the two arrays, backdoor muxing and `fetch_cnt`.

## Test plan
- Reset, load instruction word 16'h1261 at 0x3000, I_LAT=0, pulse `instrmem_rd` with `pc`=0x3000 -> `complete_instr` one cycle later, `Instr_dout`=16'h1261, `fetch_cnt`=1.
- I_LAT=3, hold `instrmem_rd` high continuously -> completions exactly every 5 cycles, each one pulse wide.
- D_LAT=2, write 16'hBEEF to 0x3010, then read 0x3010 -> write complete after 3 cycles with `Data_dout` unchanged; read returns 16'hBEEF.
- Read `pc`=0x2FFF and `pc`=0x3400 (DEPTH_LOG2=10) -> `Instr_dout`=FILL, `addr_err` set and sticky.
- Simultaneous instruction and data requests, I_LAT=D_LAT=1 -> both completes in the same cycle with correct data; `load_en` held 3 cycles delays sampling by 3.
- Assert `reset` during WAIT of a data write to 0x3020 -> no `complete_data`; 0x3020 keeps its old value. Separately, DYN_LIMIT=4 -> `done` rises on the 4th fetch.
